// File: rtl/upec_miter_pkg.sv
// Shared types and default pad geometry for the two-instance UPEC output miter.
// Imported by upec_output_miter.
package upec_miter_pkg;

    typedef enum logic [1:0] {
        MitIdle,
        MitSettle,
        MitCompare,
        MitDiverged
    } miter_state_e;

    localparam int MioPads  = 47;
    localparam int DioPads  = 24;
    localparam int ObsWidth = 2 * (MioPads + DioPads);

endpackage

// File: rtl/upec_prio_enc.sv
// Combinational lowest-set-bit encoder used to locate the first differing pad bit.
module upec_prio_enc #(
    parameter  int Width = 142,
    localparam int IdxW  = $clog2(Width)
) (
    input  logic [Width-1:0] vec,
    output logic [IdxW-1:0]  idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IdxW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/upec_output_miter.sv
// Cycle-by-cycle miter over the pad outputs of two chip copies; mismatch_o is the UPEC observable.
// Optional macro UPEC_MITER_DIFFVEC_EN captures the masked XOR vector at the first divergence.
module upec_output_miter
    import upec_miter_pkg::*;
#(
    parameter  int Width        = ObsWidth,
    parameter  int SettleCycles = 4,
    parameter  int CntWidth     = 16,
    localparam int IdxW         = $clog2(Width)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                obs_valid_i,
    input  logic [Width-1:0]    obs_a_i,
    input  logic [Width-1:0]    obs_b_i,
    input  logic [Width-1:0]    mask_i,
    output logic                comparing_o,
    output logic                mismatch_o,
    output logic [CntWidth-1:0] diverge_cycle_o,
    output logic [IdxW-1:0]     diverge_idx_o,
    output logic [CntWidth-1:0] cmp_cycles_o,
    output logic                cnt_sat_o,
    output logic [Width-1:0]    diff_vec_o
);

    localparam int SetW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam miter_state_e ArmState = (SettleCycles == 0) ? MitCompare : MitSettle;
    localparam logic [SetW-1:0] SettleLast = SetW'(SettleCycles - 1);

    miter_state_e      state;
    logic [SetW-1:0]   settle_cnt;
    logic [Width-1:0]  diff;
    logic [IdxW-1:0]   first_idx;
    logic              diff_found;
    logic              diverge_now;

    assign diff        = (obs_a_i ^ obs_b_i) & ~mask_i;
    assign diverge_now = (state == MitCompare) && obs_valid_i && diff_found && !start_i;

    upec_prio_enc #(.Width(Width)) u_prio_enc (
        .vec   (diff),
        .idx   (first_idx),
        .found (diff_found)
    );

    // start_i takes priority over any same-cycle divergence so a re-arm always starts clean.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= MitIdle;
            settle_cnt      <= '0;
            comparing_o     <= 1'b0;
            mismatch_o      <= 1'b0;
            diverge_cycle_o <= '0;
            diverge_idx_o   <= '0;
            cmp_cycles_o    <= '0;
            cnt_sat_o       <= 1'b0;
        end else if (start_i) begin
            state           <= ArmState;
            settle_cnt      <= '0;
            comparing_o     <= (ArmState == MitCompare);
            mismatch_o      <= 1'b0;
            diverge_cycle_o <= '0;
            diverge_idx_o   <= '0;
            cmp_cycles_o    <= '0;
            cnt_sat_o       <= 1'b0;
        end else begin
            case (state)
                MitSettle: begin
                    if (obs_valid_i) begin
                        if (settle_cnt == SettleLast) begin
                            state       <= MitCompare;
                            comparing_o <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                MitCompare: begin
                    if (obs_valid_i) begin
                        if (cmp_cycles_o != CntMax) begin
                            cmp_cycles_o <= cmp_cycles_o + 1'b1;
                        end
                        if (cmp_cycles_o == CntMax - 1'b1) begin
                            cnt_sat_o <= 1'b1;
                        end
                        if (diff_found) begin
                            state           <= MitDiverged;
                            comparing_o     <= 1'b0;
                            mismatch_o      <= 1'b1;
                            diverge_cycle_o <= cmp_cycles_o;
                            diverge_idx_o   <= first_idx;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef UPEC_MITER_DIFFVEC_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            diff_vec_o <= '0;
        end else if (diverge_now) begin
            diff_vec_o <= diff;
        end
    end
`else
    assign diff_vec_o = '0;
`endif

endmodule

// File: tb/tb_upec_output_miter.sv
// Scoreboard bench for upec_output_miter: directed stimulus pushes expectations, a negedge monitor checks them.
// A second instance with CntWidth=4 covers counter saturation.
module tb_upec_output_miter;

    localparam int W  = 142;
    localparam int IW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, valid;
    logic [W-1:0] obs_a, obs_b, mask;

    logic          comparing, mismatch, sat;
    logic [15:0]   dcyc, cmp;
    logic [IW-1:0] didx;
    logic [W-1:0]  dvec;

    logic          s_comparing, s_mismatch, s_sat;
    logic [3:0]    s_dcyc, s_cmp;
    logic [IW-1:0] s_didx;
    logic [W-1:0]  s_dvec;

    upec_output_miter #(.Width(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .obs_valid_i(valid),
        .obs_a_i(obs_a), .obs_b_i(obs_b), .mask_i(mask),
        .comparing_o(comparing), .mismatch_o(mismatch), .diverge_cycle_o(dcyc),
        .diverge_idx_o(didx), .cmp_cycles_o(cmp), .cnt_sat_o(sat), .diff_vec_o(dvec)
    );

    upec_output_miter #(.Width(W), .CntWidth(4)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .obs_valid_i(valid),
        .obs_a_i(obs_a), .obs_b_i(obs_b), .mask_i(mask),
        .comparing_o(s_comparing), .mismatch_o(s_mismatch), .diverge_cycle_o(s_dcyc),
        .diverge_idx_o(s_didx), .cmp_cycles_o(s_cmp), .cnt_sat_o(s_sat), .diff_vec_o(s_dvec)
    );

    typedef struct {
        string         name;
        bit            sel;
        logic          comparing;
        logic          mismatch;
        logic [15:0]   dcyc;
        logic [IW-1:0] didx;
        logic [15:0]   cmp;
        logic          sat;
        logic [W-1:0]  dvec;
    } exp_t;

    exp_t         expq[$];
    int           checks = 0;
    int           fails  = 0;
    logic [W-1:0] base;
    localparam logic [W-1:0] Z = '0;

    function automatic logic [W-1:0] bitv(input int i);
        logic [W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] expVec(input logic [W-1:0] v);
`ifdef UPEC_MITER_DIFFVEC_EN
        return v;
`else
        return v & '0;
`endif
    endfunction

    task automatic applyStimulus(input logic r, input logic st, input logic v,
                                 input logic [W-1:0] flip, input logic [W-1:0] msk);
        for (int i = 0; i < W; i++) base[i] = 1'($urandom_range(0, 1));
        rst   = r;
        start = st;
        valid = v;
        obs_a = base;
        obs_b = base ^ flip;
        mask  = msk;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit sel, input logic comp, input logic mm,
                               input logic [15:0] dc, input logic [IW-1:0] di, input logic [15:0] cc,
                               input logic st, input logic [W-1:0] dv);
        exp_t e;
        e.name = name; e.sel = sel; e.comparing = comp; e.mismatch = mm; e.dcyc = dc;
        e.didx = di; e.cmp = cc; e.sat = st; e.dvec = dv;
        expq.push_back(e);
    endtask

    task automatic check1(input string tag, input string field, input logic [W-1:0] act,
                          input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s.%s: got %0h expected %0h", tag, field, act, exp);
        end
    endtask

    // Monitor: outputs only move on posedge, so every pending expectation is checked at negedge.
    always @(negedge clk) begin
        while (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            if (e.sel) begin
                check1(e.name, "comparing", W'(s_comparing), W'(e.comparing));
                check1(e.name, "mismatch", W'(s_mismatch), W'(e.mismatch));
                check1(e.name, "diverge_cycle", W'(s_dcyc), W'(e.dcyc));
                check1(e.name, "diverge_idx", W'(s_didx), W'(e.didx));
                check1(e.name, "cmp_cycles", W'(s_cmp), W'(e.cmp));
                check1(e.name, "cnt_sat", W'(s_sat), W'(e.sat));
                check1(e.name, "diff_vec", s_dvec, e.dvec);
            end else begin
                check1(e.name, "comparing", W'(comparing), W'(e.comparing));
                check1(e.name, "mismatch", W'(mismatch), W'(e.mismatch));
                check1(e.name, "diverge_cycle", W'(dcyc), W'(e.dcyc));
                check1(e.name, "diverge_idx", W'(didx), W'(e.didx));
                check1(e.name, "cmp_cycles", W'(cmp), W'(e.cmp));
                check1(e.name, "cnt_sat", W'(sat), W'(e.sat));
                check1(e.name, "diff_vec", dvec, e.dvec);
            end
        end
    end

    task automatic armAndSettle(input logic [W-1:0] settleFlip);
        applyStimulus(0, 1, 0, Z, Z);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, settleFlip, Z);
    endtask

    initial begin
        // Reset
        applyStimulus(1, 0, 0, Z, Z);
        applyStimulus(1, 1, 1, bitv(1), Z);
        checkOutput("reset", 0, 0, 0, 0, 0, 0, 0, Z);
        checkOutput("reset_sat", 1, 0, 0, 0, 0, 0, 0, Z);

        // Settle window then equal comparisons
        applyStimulus(0, 1, 0, Z, Z);
        checkOutput("t1_armed", 0, 0, 0, 0, 0, 0, 0, Z);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, Z, Z);
        checkOutput("t1_settle3", 0, 0, 0, 0, 0, 0, 0, Z);
        applyStimulus(0, 0, 1, Z, Z);
        checkOutput("t1_settle_end", 0, 1, 0, 0, 0, 0, 0, Z);
        applyStimulus(0, 0, 0, bitv(9), Z);
        checkOutput("t1_invalid_diff", 0, 1, 0, 0, 0, 0, 0, Z);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, Z, Z);
        checkOutput("t1_equal10", 0, 1, 0, 0, 0, 10, 0, Z);

        // Divergence on bit 37 at compare cycle 5, then hold
        armAndSettle(Z);
        checkOutput("t2_settled", 0, 1, 0, 0, 0, 0, 0, Z);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, Z, Z);
        applyStimulus(0, 0, 1, bitv(37), Z);
        checkOutput("t2_diverge", 0, 0, 1, 5, 37, 6, 0, expVec(bitv(37)));
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, bitv(i + 50), Z);
        checkOutput("t2_hold", 0, 0, 1, 5, 37, 6, 0, expVec(bitv(37)));

        // Differences during settle and masked differences are ignored
        armAndSettle(bitv(3) | bitv(90));
        checkOutput("t3_settle_diff", 0, 1, 0, 0, 0, 0, 0, Z);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, Z, Z);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, bitv(90), bitv(90));
        checkOutput("t3_masked", 0, 1, 0, 0, 0, 6, 0, Z);
        applyStimulus(0, 0, 1, '1, '1);
        checkOutput("t3_mask_all", 0, 1, 0, 0, 0, 7, 0, Z);
        applyStimulus(0, 1, 1, bitv(7), Z);
        checkOutput("t3_start_wins", 0, 0, 0, 0, 0, 0, 0, Z);

        // Restart clears a latched divergence; reset mid-settle returns to idle
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, Z, Z);
        applyStimulus(0, 0, 1, bitv(100), Z);
        checkOutput("t5_diverge", 0, 0, 1, 0, 100, 1, 0, expVec(bitv(100)));
        applyStimulus(0, 1, 0, Z, Z);
        checkOutput("t5_restart", 0, 0, 0, 0, 0, 0, 0, Z);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, Z, Z);
        applyStimulus(1, 1, 1, bitv(5), Z);
        checkOutput("t5_reset", 0, 0, 0, 0, 0, 0, 0, Z);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, bitv(5), Z);
        checkOutput("t5_idle", 0, 0, 0, 0, 0, 0, 0, Z);

        // Two differing bits: lowest index reported, vector captured when enabled
        armAndSettle(Z);
        applyStimulus(0, 0, 1, bitv(2) | bitv(141), Z);
        checkOutput("t6_two_bits", 0, 0, 1, 0, 2, 1, 0, expVec(bitv(2) | bitv(141)));

        // Saturation on the CntWidth=4 instance
        applyStimulus(1, 0, 0, Z, Z);
        armAndSettle(Z);
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 1, Z, Z);
        checkOutput("t4_pre_sat", 1, 1, 0, 0, 0, 14, 0, Z);
        applyStimulus(0, 0, 1, Z, Z);
        checkOutput("t4_sat_reached", 1, 1, 0, 0, 0, 15, 1, Z);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, Z, Z);
        checkOutput("t4_sat_hold", 1, 1, 0, 0, 0, 15, 1, Z);
        applyStimulus(0, 0, 1, bitv(0), Z);
        checkOutput("t4_sat_diverge", 1, 0, 1, 15, 0, 15, 1, expVec(bitv(0)));

        applyStimulus(0, 0, 0, Z, Z);
        applyStimulus(0, 0, 0, Z, Z);
        checks++;
        if (expq.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
